// File: rtl/wb_pkg.sv
// Shared definitions for the write-back stage: default widths, the
// source-index width helper and the buffered entry layout.
package wb_pkg;

  localparam int DEF_NUM_SRC = 6;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_CODE_W  = 8;
  localparam int DEF_DEPTH   = 4;

  // Width of a source index; never narrower than one bit.
  function automatic int src_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // One queued write-back at the default widths, code in the upper bits.
  typedef struct packed {
    logic [DEF_CODE_W-1:0] code;
    logic [DEF_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Single-source synchronous FIFO. Full/empty come from the registered count,
// so a push offered while full is refused even if a pop happens that cycle.
module wb_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == {CNT_W{1'b0}});
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Entry storage; contents need no reset since count gates visibility.
  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally; count tracks occupancy.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= {PTR_W{1'b0}};
      rd_ptr <= {PTR_W{1'b0}};
      count  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: per-source FIFOs arbitrated onto one registered write
// port. Define WB_FIXED_PRIO_EN for fixed lowest-index-first priority;
// otherwise a round-robin pointer rotates priority after each grant.
module wb_stage
  import wb_pkg::*;
#(
  parameter int NUM_SRC = DEF_NUM_SRC,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int CODE_W  = DEF_CODE_W,
  parameter int DEPTH   = DEF_DEPTH,
  localparam int SRC_W  = src_w(NUM_SRC)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [NUM_SRC*CODE_W-1:0] src_code,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  output logic [NUM_SRC-1:0]        src_ready,
  input  logic                      wb_hold,
  output logic                      wb_flag,
  output logic [CODE_W-1:0]         wb_code,
  output logic [DATA_W-1:0]         wb_data,
  output logic [SRC_W-1:0]          wb_src,
  output logic [NUM_SRC-1:0]        overflow,
  output logic                      busy
);

  localparam int ENTRY_W = CODE_W + DATA_W;

  logic [NUM_SRC-1:0] full;
  logic [NUM_SRC-1:0] empty;
  logic [NUM_SRC-1:0] pop;
  logic [ENTRY_W-1:0] head [NUM_SRC];
  logic [SRC_W-1:0]   start;
  logic               gnt_valid;
  logic [SRC_W-1:0]   gnt_idx;
  logic [ENTRY_W-1:0] gnt_entry;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      wb_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
      ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (src_valid[gi]),
        .pop   (pop[gi]),
        .wdata ({src_code[gi*CODE_W +: CODE_W], src_data[gi*DATA_W +: DATA_W]}),
        .head  (head[gi]),
        .full  (full[gi]),
        .empty (empty[gi])
      );
      assign pop[gi] = gnt_valid && (gnt_idx == SRC_W'(gi));
    end
  endgenerate

  assign src_ready = ~full;
  assign busy      = (|(~empty)) | wb_flag;

`ifdef WB_FIXED_PRIO_EN
  assign start = {SRC_W{1'b0}};
`else
  logic [SRC_W-1:0] rr;
  assign start = rr;

  // Priority pointer moves just past the last granted source.
  always_ff @(posedge clock) begin
    if (reset) begin
      rr <= {SRC_W{1'b0}};
    end else if (gnt_valid) begin
      rr <= (gnt_idx == SRC_W'(NUM_SRC - 1)) ? {SRC_W{1'b0}} : gnt_idx + SRC_W'(1);
    end else begin
      rr <= rr;
    end
  end
`endif

  // Grant search: sources at or above start first, then wrap to the lowest.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = {SRC_W{1'b0}};
    gnt_entry = {ENTRY_W{1'b0}};
    if (!wb_hold) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (!gnt_valid && !empty[i] && (SRC_W'(i) >= start)) begin
          gnt_valid = 1'b1;
          gnt_idx   = SRC_W'(i);
          gnt_entry = head[i];
        end
      end
      for (int i = 0; i < NUM_SRC; i++) begin
        if (!gnt_valid && !empty[i]) begin
          gnt_valid = 1'b1;
          gnt_idx   = SRC_W'(i);
          gnt_entry = head[i];
        end
      end
    end else begin
      gnt_valid = 1'b0;
    end
  end

  // Output register: loads the granted head, otherwise drops the strobe only.
  always_ff @(posedge clock) begin
    if (reset) begin
      wb_flag <= 1'b0;
      wb_code <= {CODE_W{1'b0}};
      wb_data <= {DATA_W{1'b0}};
      wb_src  <= {SRC_W{1'b0}};
    end else if (gnt_valid) begin
      wb_flag <= 1'b1;
      wb_code <= gnt_entry[ENTRY_W-1 -: CODE_W];
      wb_data <= gnt_entry[DATA_W-1:0];
      wb_src  <= gnt_idx;
    end else begin
      wb_flag <= 1'b0;
    end
  end

  // Sticky per-source flag for pushes refused because the FIFO was full.
  always_ff @(posedge clock) begin
    if (reset) begin
      overflow <= {NUM_SRC{1'b0}};
    end else begin
      overflow <= overflow | (src_valid & full);
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage (default parameters).
module tb_wb_stage;

  localparam int NS = 6;
  localparam int DW = 32;
  localparam int CW = 8;
  localparam int SW = 3;

  logic             clock = 1'b0;
  logic             reset;
  logic [NS-1:0]    src_valid;
  logic [NS*CW-1:0] src_code;
  logic [NS*DW-1:0] src_data;
  logic [NS-1:0]    src_ready;
  logic             wb_hold;
  logic             wb_flag;
  logic [CW-1:0]    wb_code;
  logic [DW-1:0]    wb_data;
  logic [SW-1:0]    wb_src;
  logic [NS-1:0]    overflow;
  logic             busy;

  int n_tests = 0;
  int n_fail  = 0;

  wb_stage dut (
    .clock     (clock),
    .reset     (reset),
    .src_valid (src_valid),
    .src_code  (src_code),
    .src_data  (src_data),
    .src_ready (src_ready),
    .wb_hold   (wb_hold),
    .wb_flag   (wb_flag),
    .wb_code   (wb_code),
    .wb_data   (wb_data),
    .wb_src    (wb_src),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_src(input int i, input logic [CW-1:0] c, input logic [DW-1:0] d);
    src_valid[i]           = 1'b1;
    src_code[i*CW +: CW]   = c;
    src_data[i*DW +: DW]   = d;
  endtask

  task automatic clear_src();
    src_valid = '0;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    wb_hold   = 1'b0;
    src_valid = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    src_code = '0;
    src_data = '0;
    do_reset();
    n_tests++; if (wb_flag !== 1'b0) begin n_fail++; $display("FAIL rst_flag: got %b exp 0", wb_flag); end
    n_tests++; if (wb_code !== 8'h00) begin n_fail++; $display("FAIL rst_code: got %h exp 00", wb_code); end
    n_tests++; if (wb_data !== 32'h0) begin n_fail++; $display("FAIL rst_data: got %h exp 0", wb_data); end
    n_tests++; if (wb_src !== 3'd0) begin n_fail++; $display("FAIL rst_src: got %0d exp 0", wb_src); end
    n_tests++; if (overflow !== 6'b0) begin n_fail++; $display("FAIL rst_ovf: got %b exp 000000", overflow); end
    n_tests++; if (src_ready !== 6'b111111) begin n_fail++; $display("FAIL rst_ready: got %b exp 111111", src_ready); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b exp 0", busy); end
  endtask

  task automatic test_latency();
    do_reset();
    set_src(2, 8'h05, 32'hDEADBEEF);
    step();
    clear_src();
    n_tests++; if (wb_flag !== 1'b0) begin n_fail++; $display("FAIL lat_early: got %b exp 0", wb_flag); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL lat_busy_q: got %b exp 1", busy); end
    step();
    n_tests++; if (wb_flag !== 1'b1) begin n_fail++; $display("FAIL lat_flag: got %b exp 1", wb_flag); end
    n_tests++; if (wb_code !== 8'h05) begin n_fail++; $display("FAIL lat_code: got %h exp 05", wb_code); end
    n_tests++; if (wb_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lat_data: got %h exp deadbeef", wb_data); end
    n_tests++; if (wb_src !== 3'd2) begin n_fail++; $display("FAIL lat_src: got %0d exp 2", wb_src); end
    step();
    n_tests++; if (wb_flag !== 1'b0) begin n_fail++; $display("FAIL lat_after: got %b exp 0", wb_flag); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL lat_busy_end: got %b exp 0", busy); end
  endtask

  task automatic test_collision();
    logic [CW-1:0] ec;
    logic [DW-1:0] ed;
    do_reset();
    for (int rep = 0; rep < 2; rep++) begin
      for (int i = 0; i < NS; i++) begin
        set_src(i, CW'(i + 1), 32'hA000_0000 + DW'(rep * 16 + i));
      end
      step();
      clear_src();
      n_tests++; if (wb_flag !== 1'b0) begin n_fail++; $display("FAIL col_early: rep %0d got %b exp 0", rep, wb_flag); end
      for (int k = 0; k < NS; k++) begin
        step();
        ec = CW'(k + 1);
        ed = 32'hA000_0000 + DW'(rep * 16 + k);
        n_tests++; if (wb_flag !== 1'b1) begin n_fail++; $display("FAIL col_flag: rep %0d slot %0d got %b exp 1", rep, k, wb_flag); end
        n_tests++; if (wb_src !== SW'(k)) begin n_fail++; $display("FAIL col_src: rep %0d slot %0d got %0d exp %0d", rep, k, wb_src, k); end
        n_tests++; if (wb_code !== ec) begin n_fail++; $display("FAIL col_code: rep %0d slot %0d got %h exp %h", rep, k, wb_code, ec); end
        n_tests++; if (wb_data !== ed) begin n_fail++; $display("FAIL col_data: rep %0d slot %0d got %h exp %h", rep, k, wb_data, ed); end
      end
      step();
      n_tests++; if (wb_flag !== 1'b0) begin n_fail++; $display("FAIL col_end: rep %0d got %b exp 0", rep, wb_flag); end
    end
  endtask

  task automatic test_overflow();
    logic [CW-1:0] ec;
    do_reset();
    wb_hold = 1'b1;
    for (int n = 0; n < 5; n++) begin
      n_tests++; if (src_ready[1] !== (n < 4)) begin n_fail++; $display("FAIL ovf_ready: push %0d got %b exp %b", n, src_ready[1], (n < 4)); end
      set_src(1, 8'h10 + CW'(n), 32'h1111_0000 + DW'(n));
      step();
      n_tests++; if (wb_flag !== 1'b0) begin n_fail++; $display("FAIL ovf_hold_flag: push %0d got %b exp 0", n, wb_flag); end
    end
    clear_src();
    n_tests++; if (overflow !== 6'b000010) begin n_fail++; $display("FAIL ovf_flag: got %b exp 000010", overflow); end
    wb_hold = 1'b0;
    for (int n = 0; n < 4; n++) begin
      step();
      ec = 8'h10 + CW'(n);
      n_tests++; if (wb_flag !== 1'b1) begin n_fail++; $display("FAIL ovf_drain_flag: %0d got %b exp 1", n, wb_flag); end
      n_tests++; if (wb_code !== ec) begin n_fail++; $display("FAIL ovf_drain_code: %0d got %h exp %h", n, wb_code, ec); end
      n_tests++; if (wb_src !== 3'd1) begin n_fail++; $display("FAIL ovf_drain_src: %0d got %0d exp 1", n, wb_src); end
    end
    step();
    n_tests++; if (wb_flag !== 1'b0) begin n_fail++; $display("FAIL ovf_extra: got %b exp 0", wb_flag); end
    n_tests++; if (overflow !== 6'b000010) begin n_fail++; $display("FAIL ovf_sticky: got %b exp 000010", overflow); end
  endtask

  task automatic test_fairness();
    logic [SW-1:0] es;
    logic [CW-1:0] ec;
    int j;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      if (c < 3) begin
        set_src(0, 8'h20 + CW'(c), 32'h2000_0000 + DW'(c));
        set_src(3, 8'h30 + CW'(c), 32'h3000_0000 + DW'(c));
      end else begin
        clear_src();
      end
      step();
      j = c - 1;
      if (j >= 0 && j < 6) begin
`ifdef WB_FIXED_PRIO_EN
        es = (j < 3) ? 3'd0 : 3'd3;
        ec = (j < 3) ? 8'h20 + CW'(j) : 8'h30 + CW'(j - 3);
`else
        es = (j % 2 == 0) ? 3'd0 : 3'd3;
        ec = (j % 2 == 0) ? 8'h20 + CW'(j / 2) : 8'h30 + CW'(j / 2);
`endif
        n_tests++; if (wb_flag !== 1'b1) begin n_fail++; $display("FAIL fair_flag: slot %0d got %b exp 1", j, wb_flag); end
        n_tests++; if (wb_src !== es) begin n_fail++; $display("FAIL fair_src: slot %0d got %0d exp %0d", j, wb_src, es); end
        n_tests++; if (wb_code !== ec) begin n_fail++; $display("FAIL fair_code: slot %0d got %h exp %h", j, wb_code, ec); end
      end else if (j == 6) begin
        n_tests++; if (wb_flag !== 1'b0) begin n_fail++; $display("FAIL fair_end: got %b exp 0", wb_flag); end
      end
    end
  endtask

  task automatic test_hold();
    do_reset();
    wb_hold = 1'b1;
    set_src(4, 8'h41, 32'h4444_4444);
    set_src(5, 8'h51, 32'h5555_5555);
    step();
    clear_src();
    for (int n = 0; n < 3; n++) begin
      n_tests++; if (wb_flag !== 1'b0) begin n_fail++; $display("FAIL hold_flag: cycle %0d got %b exp 0", n, wb_flag); end
      if (n < 2) step();
    end
    wb_hold = 1'b0;
    step();
    n_tests++; if (wb_flag !== 1'b1 || wb_src !== 3'd4 || wb_code !== 8'h41) begin
      n_fail++; $display("FAIL hold_first: got flag %b src %0d code %h exp 1 4 41", wb_flag, wb_src, wb_code);
    end
    step();
    n_tests++; if (wb_flag !== 1'b1 || wb_src !== 3'd5 || wb_data !== 32'h5555_5555) begin
      n_fail++; $display("FAIL hold_second: got flag %b src %0d data %h exp 1 5 55555555", wb_flag, wb_src, wb_data);
    end
    step();
    n_tests++; if (wb_flag !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL hold_end: got flag %b busy %b exp 0 0", wb_flag, busy);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    wb_hold = 1'b1;
    set_src(0, 8'h60, 32'h6000_0000);
    set_src(1, 8'h61, 32'h6100_0000);
    set_src(2, 8'h62, 32'h6200_0000);
    step();
    clear_src();
    for (int n = 0; n < 4; n++) begin
      set_src(0, 8'h70 + CW'(n), 32'h7000_0000 + DW'(n));
      step();
    end
    clear_src();
    n_tests++; if (overflow !== 6'b000001) begin n_fail++; $display("FAIL rm_pre_ovf: got %b exp 000001", overflow); end
    reset   = 1'b1;
    wb_hold = 1'b0;
    step();
    n_tests++; if (wb_flag !== 1'b0) begin n_fail++; $display("FAIL rm_flag: got %b exp 0", wb_flag); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rm_busy: got %b exp 0", busy); end
    n_tests++; if (overflow !== 6'b0) begin n_fail++; $display("FAIL rm_ovf: got %b exp 000000", overflow); end
    n_tests++; if (src_ready !== 6'b111111) begin n_fail++; $display("FAIL rm_ready: got %b exp 111111", src_ready); end
    reset = 1'b0;
    for (int n = 0; n < 6; n++) begin
      step();
      n_tests++; if (wb_flag !== 1'b0) begin n_fail++; $display("FAIL rm_stale: cycle %0d got %b exp 0", n, wb_flag); end
    end
  endtask

  initial begin
    reset     = 1'b1;
    wb_hold   = 1'b0;
    src_valid = '0;
    src_code  = '0;
    src_data  = '0;
    test_reset();
    test_latency();
    test_collision();
    test_overflow();
    test_fairness();
    test_hold();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
